// File: rtl/imem_read_arbiter.sv
// Two-requester arbiter for the instruction memory read port.
// Optional round-robin tie break: define IMEM_ARB_RR_EN.
module imem_read_arbiter #(
  parameter int DEPTH    = 64,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic {
    LAST_F = 1'b0,
    LAST_D = 1'b1
  } last_e;

  last_e             r_last;
  last_e             w_last_nxt;
  logic [CW-1:0]     r_wait_cnt;
  logic [CW-1:0]     w_wait_nxt;
  logic              w_force_d;
  logic              w_tie_f;
  logic              w_f_gnt;
  logic              w_d_gnt;
  logic              w_any_gnt;
  logic [31:0]       w_gnt_addr;
  logic              w_legal;
  logic [DATA_W-1:0] w_rd_word;

  assign w_force_d = (r_wait_cnt == WAIT_MAX);

`ifdef IMEM_ARB_RR_EN
  assign w_tie_f = (r_last == LAST_D);
`else
  assign w_tie_f = 1'b1;
`endif

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    w_f_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!reset) begin
      unique case ({f_req, d_req})
        2'b10: w_f_gnt = 1'b1;
        2'b01: w_d_gnt = 1'b1;
        2'b11: begin
          if (!w_force_d && w_tie_f) begin
            w_f_gnt = 1'b1;
          end else begin
            w_d_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_any_gnt  = w_f_gnt | w_d_gnt;
  assign w_gnt_addr = w_f_gnt ? f_addr : d_addr;
  assign w_legal    = (w_gnt_addr[1:0] == 2'b00)
                   && (w_gnt_addr[31:2] < DEPTH_W);
  assign w_rd_word  = w_legal ? mem_rdata : '0;

  assign f_gnt    = w_f_gnt;
  assign d_gnt    = w_d_gnt;
  assign mem_addr = (w_any_gnt && w_legal) ? w_gnt_addr : '0;

  // Count consecutive denied D cycles, saturating at the limit
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!d_req || w_d_gnt) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      w_wait_nxt = r_wait_cnt + CW'(1);
    end
  end

  // Next "last granted" side; held when idle
  always_comb begin
    w_last_nxt = r_last;
    unique case (1'b1)
      w_f_gnt: w_last_nxt = LAST_F;
      w_d_gnt: w_last_nxt = LAST_D;
      default: ;
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_last     <= LAST_D;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      r_last     <= w_last_nxt;
    end
  end

  // Fetch-side response: one-cycle pulse, data held until next grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      f_err    <= 1'b0;
    end else begin
      f_rvalid <= w_f_gnt;
      if (w_f_gnt) begin
        f_rdata <= w_rd_word;
        f_err   <= ~w_legal;
      end
    end
  end

  // Data-side response: one-cycle pulse, data held until next grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      d_rvalid <= w_d_gnt;
      if (w_d_gnt) begin
        d_rdata <= w_rd_word;
        d_err   <= ~w_legal;
      end
    end
  end

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Self-checking bench for imem_read_arbiter.
// Honours IMEM_ARB_RR_EN when the design is built with it.
module tb_imem_read_arbiter;
  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int MW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, d_req;
  logic [31:0]   f_addr, d_addr;
  logic          f_gnt, d_gnt;
  logic          f_rvalid, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata;
  logic          f_err, d_err;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  imem_read_arbiter #(
    .DEPTH(DEPTH), .DATA_W(DW), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < DEPTH);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [5:0] idx;
    idx = a[7:2];
    return legal(a) ? mem[idx] : 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
      1: return $urandom_range(64, 5000) << 2;
      2: return 32'h0000_00FC;
      3: return {$urandom_range(1, 255), 24'h0};
      default: return $urandom_range(0, 63) << 2;
    endcase
  endfunction

  // Leaves the bench just after a falling edge with reset low
  task automatic do_reset();
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0;
    f_addr = '0; d_addr = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({f_rvalid, d_rvalid, f_err, d_err} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {f_rvalid, d_rvalid, f_err, d_err});
    end
    total++;
    if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", f_rdata, d_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    f_req = 1'b1; f_addr = 32'h8;
    d_req = 1'b1; d_addr = 32'h4;
    #1;
    total++;
    if (f_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_gnt: got f=%b d=%b a=%h want 0 0 0",
               f_gnt, d_gnt, mem_addr);
    end
    @(posedge clk); #1;
    total++;
    if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_rv: got %b%b want 00", f_rvalid, d_rvalid);
    end
    do_reset();
  endtask

  task automatic test_fetch_basic();
    f_req = 1'b1; f_addr = 32'h0000_0008;
    #1;
    total++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 32'h8) begin
      bad++;
      $display("FAIL fetch_gnt: got f=%b d=%b a=%h want 1 0 8",
               f_gnt, d_gnt, mem_addr);
    end
    @(posedge clk); #1;
    f_req = 1'b0;
    total++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'hE3A0_1005 || f_err !== 1'b0) begin
      bad++;
      $display("FAIL fetch_rsp: got v=%b d=%h e=%b want 1 e3a01005 0",
               f_rvalid, f_rdata, f_err);
    end
    total++;
    if (d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_drv: got %b want 0", d_rvalid);
    end
    @(posedge clk); #1;
    total++;
    if (f_rvalid !== 1'b0 || f_rdata !== 32'hE3A0_1005) begin
      bad++;
      $display("FAIL fetch_hold: got v=%b d=%h want 0 e3a01005",
               f_rvalid, f_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit exp_f [6];
`ifdef IMEM_ARB_RR_EN
    exp_f = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_f = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    f_req = 1'b1; f_addr = 32'h10;
    d_req = 1'b1; d_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (f_gnt !== exp_f[i] || d_gnt !== !exp_f[i]) begin
        bad++;
        $display("FAIL starve_gnt[%0d]: got f=%b d=%b want f=%b",
                 i, f_gnt, d_gnt, exp_f[i]);
      end
      @(posedge clk); #1;
      total++;
      if (f_rvalid !== exp_f[i] || d_rvalid !== !exp_f[i]) begin
        bad++;
        $display("FAIL starve_rv[%0d]: got f=%b d=%b want f=%b",
                 i, f_rvalid, d_rvalid, exp_f[i]);
      end
      @(negedge clk);
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_check();
    logic [31:0] addrs [3];
    logic [31:0] e_ma  [3];
    logic [31:0] e_dat [3];
    bit          e_err [3];
    addrs = '{32'h102, 32'h100, 32'hFC};
    e_ma  = '{32'h0, 32'h0, 32'hFC};
    e_dat = '{32'h0, 32'h0, mem[63]};
    e_err = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_addr = addrs[i];
      #1;
      total++;
      if (d_gnt !== 1'b1 || mem_addr !== e_ma[i]) begin
        bad++;
        $display("FAIL addr_gnt[%0d]: got g=%b a=%h want 1 %h",
                 i, d_gnt, mem_addr, e_ma[i]);
      end
      @(posedge clk); #1;
      total++;
      if (d_rvalid !== 1'b1 || d_rdata !== e_dat[i] || d_err !== e_err[i]) begin
        bad++;
        $display("FAIL addr_rsp[%0d]: got v=%b d=%h e=%b want 1 %h %b",
                 i, d_rvalid, d_rdata, d_err, e_dat[i], e_err[i]);
      end
      @(negedge clk);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midcycle();
    f_req = 1'b1; f_addr = 32'h8;
    #1;
    total++;
    if (f_gnt !== 1'b1) begin
      bad++;
      $display("FAIL mid_gnt: got %b want 1", f_gnt);
    end
    #1 reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_rsp: got v=%b d=%h want 0 0", f_rvalid, f_rdata);
    end
    @(negedge clk);
    f_req = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL mid_replay: got %b%b want 00", f_rvalid, d_rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int          m_wait;
    bit          m_last_d;
    bit          eg_f, eg_d;
    logic [31:0] e_ma;
    logic [31:0] e_fd, e_dd;
    bit          e_fe, e_de;
    bit          pend_f, pend_d;
    do_reset();
    m_wait = 0; m_last_d = 1'b1;
    e_fd = '0; e_dd = '0; e_fe = 1'b0; e_de = 1'b0;
    pend_f = 1'b0; pend_d = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!(pend_f && $urandom_range(0, 7) != 0)) begin
        f_req = ($urandom_range(0, 3) != 0);
        f_addr = rand_addr();
      end
      if (!(pend_d && $urandom_range(0, 7) != 0)) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_addr = rand_addr();
      end
      eg_f = 1'b0; eg_d = 1'b0;
      if (f_req && d_req) begin
        if (m_wait == MW) eg_d = 1'b1;
`ifdef IMEM_ARB_RR_EN
        else if (m_last_d) eg_f = 1'b1;
        else eg_d = 1'b1;
`else
        else eg_f = 1'b1;
`endif
      end else begin
        eg_f = f_req;
        eg_d = d_req;
      end
      e_ma = 32'h0;
      if (eg_f && legal(f_addr)) e_ma = f_addr;
      if (eg_d && legal(d_addr)) e_ma = d_addr;
      #1;
      total++;
      if (f_gnt !== eg_f || d_gnt !== eg_d || mem_addr !== e_ma) begin
        bad++;
        $display("FAIL rnd_gnt[%0d]: got f=%b d=%b a=%h want %b %b %h",
                 n, f_gnt, d_gnt, mem_addr, eg_f, eg_d, e_ma);
      end
      if (d_req && !eg_d) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      else m_wait = 0;
      if (eg_f) begin
        m_last_d = 1'b0;
        e_fd = word_of(f_addr);
        e_fe = !legal(f_addr);
      end
      if (eg_d) begin
        m_last_d = 1'b1;
        e_dd = word_of(d_addr);
        e_de = !legal(d_addr);
      end
      pend_f = f_req && !eg_f;
      pend_d = d_req && !eg_d;
      @(posedge clk); #1;
      total++;
      if (f_rvalid !== eg_f || f_rdata !== e_fd || f_err !== e_fe) begin
        bad++;
        $display("FAIL rnd_f[%0d]: got v=%b d=%h e=%b want %b %h %b",
                 n, f_rvalid, f_rdata, f_err, eg_f, e_fd, e_fe);
      end
      total++;
      if (d_rvalid !== eg_d || d_rdata !== e_dd || d_err !== e_de) begin
        bad++;
        $display("FAIL rnd_d[%0d]: got v=%b d=%h e=%b want %b %h %b",
                 n, d_rvalid, d_rdata, d_err, eg_d, e_dd, e_de);
      end
      @(negedge clk);
    end
    f_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0;
    f_addr = '0; d_addr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[2] = 32'hE3A0_1005;
    @(negedge clk);
    test_reset();
    test_fetch_basic();
    test_starvation();
    test_addr_check();
    test_reset_midcycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
